// File: rtl/adam_clk_div_pkg.sv
// Shared types and helpers for the adam_clk_div_ctrl clock divider.
// Controller FSM encoding, smallest legal ratio and the high-phase length rule.
package adam_clk_div_pkg;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_PEND  = 2'd1,
    ST_GATED = 2'd2
  } state_e;

  localparam int unsigned DIV_MIN = 1;

  // Length of the high phase: odd ratios keep the clock high one cycle longer.
  function automatic int unsigned ceil_half(input int unsigned n);
    return (n + 1) >> 1;
  endfunction

endpackage

// File: rtl/adam_clk_div_cnt.sv
// Period counter for adam_clk_div_ctrl: wrap detect plus registered divided
// clock and period tick, both derived from the next counter value.
module adam_clk_div_cnt
  import adam_clk_div_pkg::*;
#(
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [DIV_W-1:0] ratio,
  input  logic             clear,
  input  logic             enable,
  output logic             wrap,
  output logic             div_clk,
  output logic             div_tick
);

  logic [DIV_W-1:0] cnt_q;
  logic [DIV_W-1:0] cnt_d;
  logic [DIV_W-1:0] hi_len;

  assign wrap   = (cnt_q == (ratio - DIV_W'(DIV_MIN)));
  assign hi_len = DIV_W'(ceil_half(32'(ratio)));

  // A disabled counter parks at zero; clear restarts a period immediately.
  always_comb begin
    cnt_d = cnt_q + DIV_W'(1);
    if (!enable || clear || wrap) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      div_clk  <= 1'b0;
      div_tick <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      div_clk  <= enable && (cnt_d < hi_len);
      div_tick <= enable && (cnt_d == '0);
    end
  end

endmodule

// File: rtl/adam_clk_div_ctrl.sv
// Runtime-programmable glitch-free clock divider with valid/ready ratio config.
// Optional output gating (gate_req/gate_ack) when ADAM_CLK_DIV_CTRL_GATE_EN is defined.
module adam_clk_div_ctrl
  import adam_clk_div_pkg::*;
#(
  parameter int DIV_W   = 8,
  parameter int DEF_DIV = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_valid,
  input  logic [DIV_W-1:0] cfg_div,
  output logic             cfg_ready,
  output logic             cfg_err,
  output logic [DIV_W-1:0] cur_div,
  output logic             busy,
`ifdef ADAM_CLK_DIV_CTRL_GATE_EN
  input  logic             gate_req,
  output logic             gate_ack,
`endif
  output logic             div_clk_o,
  output logic             div_tick_o
);

  state_e           state_q;
  state_e           state_d;
  logic [DIV_W-1:0] pend_q;
  logic             accept;
  logic             req_zero;
  logic             req_ok;
  logic             wrap;
  logic             gate_on;
  logic             gated;
  logic             cnt_en;
  logic             cnt_clr;

`ifdef ADAM_CLK_DIV_CTRL_GATE_EN
  assign gate_on  = gate_req;
  assign gate_ack = gated;
`else
  assign gate_on  = 1'b0;
`endif

  assign accept   = cfg_valid && cfg_ready;
  assign req_zero = accept && (cfg_div < DIV_W'(DIV_MIN));
  assign req_ok   = accept && !req_zero;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // Pending ratio changes win over gating; both only act on a period wrap.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN: begin
        if (req_ok) begin
          state_d = ST_PEND;
        end else if (gate_on && wrap) begin
          state_d = ST_GATED;
        end
      end
      ST_PEND: begin
        if (wrap) begin
          state_d = ST_RUN;
        end
      end
      ST_GATED: begin
        if (!gate_on) begin
          state_d = ST_RUN;
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  always_comb begin
    cfg_ready = 1'b1;
    busy      = 1'b0;
    gated     = 1'b0;
    case (state_q)
      ST_PEND: begin
        cfg_ready = 1'b0;
        busy      = 1'b1;
      end
      ST_GATED: gated = 1'b1;
      default: ;
    endcase
  end

  // Entering or holding GATED silences the outputs; leaving restarts a period.
  assign cnt_en  = (state_d != ST_GATED);
  assign cnt_clr = gated && (state_d == ST_RUN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_div <= DIV_W'(DEF_DIV);
      pend_q  <= '0;
      cfg_err <= 1'b0;
    end else begin
      cfg_err <= req_zero;
      if ((state_q == ST_RUN) && req_ok) begin
        pend_q <= cfg_div;
      end
      if ((state_q == ST_PEND) && wrap) begin
        cur_div <= pend_q;
      end else if (gated && req_ok) begin
        cur_div <= cfg_div;
      end
    end
  end

  adam_clk_div_cnt #(
    .DIV_W (DIV_W)
  ) u_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .ratio    (cur_div),
    .clear    (cnt_clr),
    .enable   (cnt_en),
    .wrap     (wrap),
    .div_clk  (div_clk_o),
    .div_tick (div_tick_o)
  );

endmodule
